// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - loads a length-prefixed little-endian byte stream into instruction memory
module imem_stream_loader #(
    parameter int unsigned MEM_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [1:0]  byte_idx;
    logic [31:0] hdr_count;
    logic [31:0] word_cnt;
    logic [31:0] asm_word;
    logic [31:0] hdr_shift;
    logic [31:0] asm_shift;
    logic        xfer;
    logic        last_byte;
    logic        restart;

    assign xfer      = byte_valid && byte_ready;
    assign last_byte = xfer && (byte_idx == 2'd3);
    assign restart   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    // Bytes arrive LSB first, so each new byte enters at the top and slides down.
    assign hdr_shift = {byte_data, hdr_count[31:8]};
    assign asm_shift = {byte_data, asm_word[31:8]};

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nx = S_HDR;
            end
            S_HDR: begin
                if (last_byte) begin
                    if (hdr_shift == 32'd0)
                        state_nx = S_DONE;
                    else if (hdr_shift > 32'(MEM_WORDS))
                        state_nx = S_ERR;
                    else
                        state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (last_byte) state_nx = S_WRITE;
            end
            S_WRITE: begin
                state_nx = ((word_cnt + 32'd1) == hdr_count) ? S_DONE : S_DATA;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_idx   <= 2'd0;
            hdr_count  <= 32'd0;
            word_cnt   <= 32'd0;
            asm_word   <= 32'd0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= BASE_ADDR;
            wr_data    <= 32'd0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state <= state_nx;

            // Outputs follow the next state so they are flop-driven and aligned with it.
            byte_ready <= (state_nx == S_HDR) || (state_nx == S_DATA);
            wr_en      <= (state_nx == S_WRITE);
            busy       <= (state_nx == S_HDR) || (state_nx == S_DATA) || (state_nx == S_WRITE);
            done       <= (state_nx == S_DONE);
            error      <= (state_nx == S_ERR);
            cpu_hold   <= (state_nx != S_DONE);

            if (restart) begin
                byte_idx  <= 2'd0;
                hdr_count <= 32'd0;
                word_cnt  <= 32'd0;
                asm_word  <= 32'd0;
                wr_addr   <= BASE_ADDR;
            end

            if (xfer) begin
                byte_idx <= byte_idx + 2'd1;
                if (state == S_HDR)
                    hdr_count <= hdr_shift;
                else
                    asm_word <= asm_shift;
            end

            if ((state == S_DATA) && last_byte)
                wr_data <= asm_shift;

            // Address advances only after the write so it is stable through WRITE.
            if (state == S_WRITE) begin
                word_cnt <= word_cnt + 32'd1;
                wr_addr  <= wr_addr + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb/tb_imem_stream_loader.sv - directed scoreboard bench for imem_stream_loader
module tb_imem_stream_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int n_assert = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_addr;

    imem_stream_loader #(.MEM_WORDS(16384), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            logic [63:0] e;
            n_wr++;
            chk("ready_low_in_write", 32'(byte_ready), 32'd0);
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_write observed=%h@%h expected=none", wr_data, wr_addr);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", wr_addr, e[63:32]);
                chk("wr_data", wr_data, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            tick();
            t++;
        end
        n_assert++;
        assert (byte_ready) else begin
            n_fail++;
            $error("FAIL byte_timeout observed=ready_low expected=ready_high byte=%h", b);
        end
        tick();
    endtask

    task automatic send_hdr(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
        exp_addr = BASE;
    endtask

    // gap_after: hold byte_valid low for 3 cycles after that byte index; start_at: raise start with that byte
    task automatic send_word(input logic [31:0] w, input int gap_after, input int start_at);
        for (int i = 0; i < 4; i++) begin
            if (i == start_at) start = 1'b1;
            send_byte(w[8*i +: 8]);
            start = 1'b0;
            if (i == gap_after) begin
                byte_valid = 1'b0;
                repeat (3) tick();
            end
        end
        sb.push_back({exp_addr, w});
        exp_addr = exp_addr + 32'd4;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        byte_valid = 1'b0;
        while (!(done || error) && t < 100) begin
            tick();
            t++;
        end
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_addr"}, wr_addr, BASE);
    endtask

    initial begin
        exp_addr = BASE;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset");
        chk("reset_wr_data", wr_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Two-word image
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(byte_ready), 32'd1);
        send_hdr(32'd2);
        send_word(32'h0000_0013, -1, -1);
        send_word(32'h0000_006F, -1, -1);
        wait_end();
        chk("img1_done", 32'(done), 32'd1);
        chk("img1_hold", 32'(cpu_hold), 32'd0);
        chk("img1_busy", 32'(busy), 32'd0);
        chk("img1_writes", 32'(n_wr), 32'd2);

        // Empty image: done on the cycle after the 4th header byte
        pulse_start();
        chk("restart_done_clr", 32'(done), 32'd0);
        send_hdr(32'd0);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_hold", 32'(cpu_hold), 32'd0);
        byte_valid = 1'b0;
        repeat (2) tick();
        chk("empty_writes", 32'(n_wr), 32'd2);

        // Oversized header
        pulse_start();
        send_hdr(32'd16385);
        byte_valid = 1'b0;
        chk("big_error", 32'(error), 32'd1);
        chk("big_hold", 32'(cpu_hold), 32'd1);
        chk("big_busy", 32'(busy), 32'd0);
        chk("big_done", 32'(done), 32'd0);
        repeat (2) tick();
        chk("big_writes", 32'(n_wr), 32'd2);
        pulse_start();
        chk("err_clr", 32'(error), 32'd0);
        chk("err_busy", 32'(busy), 32'd1);
        chk("err_hold", 32'(cpu_hold), 32'd1);

        // Gap after byte 2 of word 0
        send_hdr(32'd1);
        send_word(32'hDEAD_BEEF, 1, -1);
        wait_end();
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_writes", 32'(n_wr), 32'd3);

        // start raised during DATA is ignored
        pulse_start();
        send_hdr(32'd2);
        send_word(32'hCAFE_0001, -1, -1);
        send_word(32'hCAFE_0002, -1, 2);
        wait_end();
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_writes", 32'(n_wr), 32'd5);
        pulse_start();
        chk("second_done_clr", 32'(done), 32'd0);
        chk("second_hold", 32'(cpu_hold), 32'd1);
        send_hdr(32'd1);
        send_word(32'h1234_5678, -1, -1);
        wait_end();
        chk("second_done", 32'(done), 32'd1);
        chk("second_writes", 32'(n_wr), 32'd6);

        // Reset asserted in the middle of word 1
        pulse_start();
        send_hdr(32'd3);
        send_word(32'hA5A5_0000, -1, -1);
        send_byte(8'h11);
        send_byte(8'h22);
        byte_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        chk("midrst_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        send_hdr(32'd2);
        send_word(32'h0BAD_F00D, -1, -1);
        send_word(32'h7777_8888, -1, -1);
        wait_end();
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_hold", 32'(cpu_hold), 32'd0);
        chk("total_writes", 32'(n_wr), 32'd9);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Writer side of the read-only instruction memory: loads a program image from a byte stream (UART/debug bridge) into instruction memory before the core starts fetching.
- Assembles little-endian 32-bit words and drives a single-cycle word write port.
- Holds the CPU in reset until the image is complete.
- Sits between the host byte-stream receiver and the instruction memory write port. The memory's fetch port stays combinational and read-only.

Parameters:
- MEM_WORDS, 16384, capacity in 32-bit words (64 KB).
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be word-aligned.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_valid  input  1  byte_data holds a valid stream byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  32  byte address of the write; always word-aligned (wr_addr[1:0]=0).
- wr_data  output  32  assembled word.
- cpu_hold  output  1  holds the core in reset while high.
- busy  output  1  load in progress (HDR, DATA or WRITE).
- done  output  1  image loaded successfully; sticky until the next start.
- error  output  1  header word count exceeds MEM_WORDS; sticky until the next start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE; all counters cleared.
  - byte_ready, wr_en, busy, done and error are 0; wr_addr = BASE_ADDR; wr_data = 0.
  - cpu_hold = 1.
- Stream format:
  - Bytes 0-3 form the header: word count N, least significant byte first.
  - N words follow, 4 bytes each, little-endian: the first byte goes to bits [7:0], the fourth to bits [31:24].
- States:
  - IDLE: byte_ready=0. On start → HDR; clear byte index, word count and address, and set cpu_hold=1.
  - HDR: byte_ready=1. Each accepted byte is shifted into N. On the 4th byte:
    - N==0 → DONE.
    - N>MEM_WORDS → ERR.
    - otherwise → DATA.
  - DATA: byte_ready=1. Each accepted byte is shifted into the word assembly register. On the 4th byte, register the word and go to WRITE.
  - WRITE: exactly one cycle.
    - wr_en=1, wr_addr=BASE_ADDR+4*k (k = words already written), byte_ready=0.
    - Next cycle: k increments; if k+1==N → DONE, else → DATA.
  - DONE: done=1, cpu_hold=0, busy=0.
  - ERR: error=1, cpu_hold=1, busy=0.
- Outputs are registered, decoded from state; wr_addr and wr_data are stable for the full WRITE cycle.
- Latency: the write strobe is asserted the cycle after the 4th byte of a word is accepted.
- Throughput: at most one byte per cycle. Minimum cost per word is 5 cycles (4 bytes + 1 WRITE).
- byte_valid deasserted mid-word: the loader waits indefinitely. Partial word state and byte index are retained; no timeout.
- Bytes presented while byte_ready=0 are not consumed; the upstream source must hold them.
- start while busy is ignored and the load continues unaffected.
- start in DONE or ERR:
  - Clears done/error and reasserts cpu_hold in the same edge.
  - Re-enters HDR with counters cleared.
- Word counter and address do not wrap: N ≤ MEM_WORDS is enforced in HDR, so the last write address is BASE_ADDR+4*(MEM_WORDS-1).
- Reset asserted mid-load aborts immediately to IDLE. Any partially written image is left in memory; cpu_hold stays 1.

Test Plan:
- Reset, start, stream 02 00 00 00 | 13 00 00 00 | 6F 00 00 00 → two wr_en pulses:
  - 0x00000013 @ BASE_ADDR
  - 0x0000006F @ BASE_ADDR+4
  - then done=1, cpu_hold=0.
- Header 00 00 00 00 → no wr_en; done=1 on the cycle after the 4th byte.
- Header 01 40 00 00 (N=16385) → error=1, cpu_hold=1, no writes. A subsequent start clears error and re-enters HDR.
- Back-to-back byte_valid with a 3-cycle gap inserted after byte 2 of word 0:
  - word still assembles to EF BE AD DE → 0xDEADBEEF;
  - byte_ready=0 during the WRITE cycle;
  - no byte is lost or duplicated.
- start pulse while in DATA → ignored, load completes normally. A second start after done → done drops, cpu_hold=1, a new load writes again from BASE_ADDR.
- rst_n low in the middle of word 1 → asynchronous return to IDLE, all outputs at reset values. After start, the stream reloads cleanly from its header.
